seri2para_rows: RTL and testbench
=================================

SERI2PARA_ROWS -- requirements
Module: seri2para_rows

Interface
REQ-001 The block SHALL have parameter COLS, default 640, meaning pixels per row (>=2).
REQ-002 The block SHALL have parameter ROWS, default 480, meaning rows per frame (>=1).
REQ-003 The block SHALL have parameter PIX_W, default 1, meaning bits per pixel (>=1); ROW_W = COLS*PIX_W.
REQ-004 The block SHALL have parameter MSB_FIRST, default 1, meaning 1 = first pixel of a row lands in the MSBs of oROW, 0 = first pixel lands in the LSBs.
REQ-005 The block SHALL have port iCLK, input, 1 bit, the single clock; all logic on its rising edge.
REQ-006 The block SHALL have port iRST_n, input, 1 bit, reset; synchronous, active-high (despite the suffix).
REQ-007 The block SHALL have port iSTART, input, 1 bit, which begins frame capture when sampled in IDLE.
REQ-008 The block SHALL have port iABORT, input, 1 bit, which terminates capture.
REQ-009 The block SHALL have port iVALID, input, 1 bit, which qualifies iPIXEL.
REQ-010 The block SHALL have port iPIXEL, input, PIX_W bits, the serial pixel data.
REQ-011 The block SHALL have port oROW, output, ROW_W bits, the completed row.
REQ-012 The block SHALL have port oROW_IDX, output, clog2(ROWS) bits (min 1), the row number of oROW.
REQ-013 The block SHALL have port oROW_VALID, output, 1 bit, meaning oROW/oROW_IDX hold an unconsumed row.
REQ-014 The block SHALL have port iROW_READY, input, 1 bit, the consumer accept.
REQ-015 The block SHALL have port oBusy, output, 1 bit, high in RUN or DRAIN.
REQ-016 The block SHALL have port oFinished, output, 1 bit, a one-cycle frame-complete pulse.
REQ-017 The block SHALL have port oOverflow, output, 1 bit, a sticky flag meaning a completed row was dropped.

Function
REQ-018 The state machine SHALL have states IDLE, RUN and DRAIN.
REQ-019 IDLE: iSTART=1 SHALL move to RUN next cycle and clear the column count, the row count and oOverflow; iSTART SHALL be ignored in RUN and DRAIN.
REQ-020 RUN: each cycle with iVALID=1, the block SHALL accept one pixel into the shift register and increment the column count; iVALID=0 SHALL leave shift register and counters unchanged.
REQ-021 MSB_FIRST=1 SHALL shift left by PIX_W with iPIXEL entering bits [PIX_W-1:0]; MSB_FIRST=0 SHALL shift right by PIX_W with iPIXEL entering the top PIX_W bits.
REQ-022 Row completion SHALL be an accepted pixel while the column count equals COLS-1; the column count SHALL then wrap to 0 and the row count SHALL increment.
REQ-023 On row completion the full row including that pixel SHALL load oROW, the current row count SHALL load oROW_IDX, and oROW_VALID SHALL be 1 on the next cycle (latency 1 cycle from the last pixel).
REQ-024 The shift register SHALL NOT be cleared between rows.
REQ-025 oROW and oROW_IDX SHALL be held stable while oROW_VALID=1 and iROW_READY=0.
REQ-026 A transfer SHALL occur when oROW_VALID=1 and iROW_READY=1 in the same cycle; oROW_VALID SHALL then fall next cycle unless a new row completes in that same cycle, in which case the new row loads and oROW_VALID stays 1.
REQ-027 Overflow: if a row completes while oROW_VALID=1 and iROW_READY=0, the new row SHALL be discarded, the held row SHALL be kept, oOverflow SHALL be set, and the row count SHALL still advance.
REQ-028 Completion of row ROWS-1 SHALL move the FSM to DRAIN, wrap the row count to 0, and stop accepting pixels.
REQ-029 DRAIN: once oROW_VALID is 0 or the final row transfers, the FSM SHALL go to IDLE and pulse oFinished for exactly one cycle on entry to IDLE.
REQ-030 iABORT=1 in RUN or DRAIN SHALL force IDLE next cycle, zero both counters and clear oROW_VALID, with no oFinished pulse; iABORT SHALL take priority over pixel acceptance and transfer in that cycle; iABORT in IDLE SHALL have no effect.
REQ-031 oOverflow SHALL remain set until the next accepted iSTART or reset.

Reset
REQ-032 With iRST_n=1 at a rising edge, the block SHALL enter IDLE, zero the counters and shift register, and drive oROW=0, oROW_IDX=0, oROW_VALID=0, oBusy=0, oFinished=0 and oOverflow=0.
REQ-033 Reset mid-frame SHALL discard all partial and held data; reset SHALL take priority over every input.

Verification (COLS=4, ROWS=2, PIX_W=2, MSB_FIRST=1 unless stated)
REQ-034 Basic frame: iSTART, then pixels 3,2,1,0 then 1,1,2,2 with iVALID=1 and iROW_READY=1 -> oROW=8'hE4 with IDX 0, then oROW=8'h5A with IDX 1, then one oFinished pulse, oOverflow=0.
REQ-035 MSB_FIRST=0 with the same stimulus -> first row oROW=8'h1B.
REQ-036 iVALID gaps inserted at random between pixels -> rows and timing relative to accepted pixels identical to REQ-034.
REQ-037 iROW_READY=0 for the whole frame -> oROW stays 8'hE4 IDX 0, oOverflow=1, FSM remains in DRAIN until ready rises, then oFinished pulses.
REQ-038 iABORT after 2 pixels of row 1 -> IDLE next cycle, oROW_VALID=0, no oFinished; a following iSTART captures a full frame correctly.
REQ-039 iRST_n pulsed mid-row with oROW_VALID=1 -> all outputs 0 on the next cycle; iSTART asserted while in RUN -> ignored.

Source files
------------

// File: rtl/seri2para_rows.sv
// -----------------------------------------------------------------------------
// seri2para_rows
//   Collects a serial pixel stream into full rows and hands each completed row
//   to a consumer through a single-entry valid/ready holding register. A frame
//   of ROWS rows is captured per iSTART. If a row completes while the previous
//   row is still waiting for the consumer, the new row is dropped and a sticky
//   overflow flag is raised.
//
// Ports
//   iCLK        : clock, rising edge
//   iRST_n      : synchronous reset, active HIGH despite the name
//   iSTART      : start frame capture (only honoured in IDLE)
//   iABORT      : abandon capture (only honoured in RUN / DRAIN)
//   iVALID      : qualifies iPIXEL
//   iPIXEL      : serial pixel, PIX_W bits
//   oROW        : completed row, COLS*PIX_W bits
//   oROW_IDX    : row number of oROW
//   oROW_VALID  : oROW / oROW_IDX hold an unconsumed row
//   iROW_READY  : consumer accepts the row when oROW_VALID is high
//   oBusy       : high in RUN or DRAIN
//   oFinished   : one-cycle pulse when a frame completes normally
//   oOverflow   : sticky, a completed row was dropped in this frame
// -----------------------------------------------------------------------------
module seri2para_rows #(
  parameter int COLS      = 640,
  parameter int ROWS      = 480,
  parameter int PIX_W     = 1,
  parameter int MSB_FIRST = 1,
  localparam int ROW_W    = COLS * PIX_W,
  localparam int IDX_W    = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic             iCLK,
  input  logic             iRST_n,
  input  logic             iSTART,
  input  logic             iABORT,
  input  logic             iVALID,
  input  logic [PIX_W-1:0] iPIXEL,
  output logic [ROW_W-1:0] oROW,
  output logic [IDX_W-1:0] oROW_IDX,
  output logic             oROW_VALID,
  input  logic             iROW_READY,
  output logic             oBusy,
  output logic             oFinished,
  output logic             oOverflow
);

  localparam int COL_W = $clog2(COLS);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
  localparam logic [IDX_W-1:0] ROW_LAST = IDX_W'(ROWS - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t           state, state_next;
  logic [COL_W-1:0] col_cnt;
  logic [IDX_W-1:0] row_cnt;
  logic [ROW_W-1:0] shreg;
  logic [ROW_W-1:0] shift_next;

  // Qualified events for this cycle.
  logic start_go, abort_go, accept, row_done, last_row, xfer, drain_done;

  assign start_go   = (state == S_IDLE) && iSTART;
  assign abort_go   = (state != S_IDLE) && iABORT;
  assign accept     = (state == S_RUN) && iVALID && !iABORT;
  assign row_done   = accept && (col_cnt == COL_LAST);
  assign last_row   = row_cnt == ROW_LAST;
  assign xfer       = oROW_VALID && iROW_READY;
  // Frame is done once nothing is held, or the held row leaves this cycle.
  assign drain_done = (state == S_DRAIN) && !iABORT && (!oROW_VALID || iROW_READY);

  // Shift direction decides whether the first pixel ends up in the MSBs or LSBs.
  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      assign shift_next = {shreg[ROW_W-PIX_W-1:0], iPIXEL};
    end else begin : g_lsb_first
      assign shift_next = {iPIXEL, shreg[ROW_W-1:PIX_W]};
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is always assigned with <= so every flop samples
  // the pre-edge values, independent of block ordering.
  always_ff @(posedge iCLK) begin
    if (iRST_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: state_next gets a default before the case so no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:  if (iSTART) state_next = S_RUN;
      S_RUN: begin
        if (iABORT)                    state_next = S_IDLE;
        else if (row_done && last_row) state_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (iABORT || drain_done) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    oBusy = (state != S_IDLE);
  end

  // Finished pulse coincides with the first cycle back in IDLE.
  always_ff @(posedge iCLK) begin
    if (iRST_n) oFinished <= 1'b0;
    else        oFinished <= drain_done;
  end

  // ---------------------------------------------------------------------------
  // Datapath: counters, shift register, row holding register, overflow
  // ---------------------------------------------------------------------------
  always_ff @(posedge iCLK) begin
    if (iRST_n) begin
      col_cnt    <= '0;
      row_cnt    <= '0;
      // NOTE: the shift register is a plain register, not a memory, so it is
      // cleared here; a reset must not leak a stale partial row.
      shreg      <= '0;
      oROW       <= '0;
      oROW_IDX   <= '0;
      oROW_VALID <= 1'b0;
      oOverflow  <= 1'b0;
    end else if (start_go) begin
      col_cnt   <= '0;
      row_cnt   <= '0;
      oOverflow <= 1'b0;
    end else if (abort_go) begin
      col_cnt    <= '0;
      row_cnt    <= '0;
      oROW_VALID <= 1'b0;
    end else begin
      if (accept) begin
        // Shift register keeps running across rows; a row is always exactly
        // the last COLS accepted pixels.
        shreg   <= shift_next;
        col_cnt <= (col_cnt == COL_LAST) ? '0 : col_cnt + 1'b1;
        if (row_done) row_cnt <= last_row ? '0 : row_cnt + 1'b1;
      end

      if (row_done) begin
        if (!oROW_VALID || iROW_READY) begin
          oROW       <= shift_next;
          oROW_IDX   <= row_cnt;
          oROW_VALID <= 1'b1;
        end else begin
          // Held row still pending: drop the new one, keep the old.
          oOverflow <= 1'b1;
        end
      end else if (xfer) begin
        oROW_VALID <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seri2para_rows.sv
// -----------------------------------------------------------------------------
// tb_seri2para_rows
//   Drives two instances (MSB-first and LSB-first) with identical stimulus and
//   compares them against a row-level reference model every cycle, plus a
//   table of hand-derived vectors for the basic frame and a few directed
//   multi-cycle sequences.
// -----------------------------------------------------------------------------
module tb_seri2para_rows;

  localparam int COLS  = 4;
  localparam int ROWS  = 2;
  localparam int PIX_W = 2;
  localparam int ROW_W = COLS * PIX_W;
  localparam int IDX_W = 1;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_DRAIN = 2;

  logic             iCLK = 1'b0;
  logic             iRST_n, iSTART, iABORT, iVALID, iROW_READY;
  logic [PIX_W-1:0] iPIXEL;

  logic [ROW_W-1:0] row_m, row_l;
  logic [IDX_W-1:0] idx_m, idx_l;
  logic             valid_m, valid_l, busy_m, busy_l, fin_m, fin_l, ovf_m, ovf_l;

  always #5 iCLK = ~iCLK;

  seri2para_rows #(.COLS(COLS), .ROWS(ROWS), .PIX_W(PIX_W), .MSB_FIRST(1)) u_dut_msb (
    .iCLK(iCLK), .iRST_n(iRST_n), .iSTART(iSTART), .iABORT(iABORT),
    .iVALID(iVALID), .iPIXEL(iPIXEL), .oROW(row_m), .oROW_IDX(idx_m),
    .oROW_VALID(valid_m), .iROW_READY(iROW_READY), .oBusy(busy_m),
    .oFinished(fin_m), .oOverflow(ovf_m)
  );

  seri2para_rows #(.COLS(COLS), .ROWS(ROWS), .PIX_W(PIX_W), .MSB_FIRST(0)) u_dut_lsb (
    .iCLK(iCLK), .iRST_n(iRST_n), .iSTART(iSTART), .iABORT(iABORT),
    .iVALID(iVALID), .iPIXEL(iPIXEL), .oROW(row_l), .oROW_IDX(idx_l),
    .oROW_VALID(valid_l), .iROW_READY(iROW_READY), .oBusy(busy_l),
    .oFinished(fin_l), .oOverflow(ovf_l)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: keeps the pixels of the row in progress and builds each
  // completed row arithmetically from that list.
  // ---------------------------------------------------------------------------
  int          m_state;
  int unsigned m_pix[$];
  int          m_rows;
  logic [63:0] m_row_msb, m_row_lsb;
  int          m_idx;
  bit          m_valid, m_fin, m_ovf;

  function automatic logic [63:0] build_row(input bit msb_first);
    logic [63:0] v = 0;
    for (int k = 0; k < COLS; k++) begin
      int sh = msb_first ? PIX_W * (COLS - 1 - k) : PIX_W * k;
      v = v + (64'(m_pix[k]) << sh);
    end
    return v;
  endfunction

  task automatic model_clear_capture();
    m_pix.delete();
    m_rows = 0;
  endtask

  task automatic model_step();
    bit xfer, fin_n;
    fin_n = 0;
    if (iRST_n) begin
      m_state = M_IDLE; model_clear_capture();
      m_row_msb = 0; m_row_lsb = 0; m_idx = 0;
      m_valid = 0; m_ovf = 0; m_fin = 0;
      return;
    end
    xfer = m_valid && iROW_READY;
    case (m_state)
      M_IDLE: begin
        if (iSTART) begin
          m_state = M_RUN; model_clear_capture(); m_ovf = 0;
        end
      end
      M_RUN: begin
        if (iABORT) begin
          m_state = M_IDLE; model_clear_capture(); m_valid = 0;
        end else begin
          bit done = 0;
          if (iVALID) begin
            m_pix.push_back(int'(iPIXEL));
            if (m_pix.size() == COLS) begin
              done = 1;
              if (!m_valid || iROW_READY) begin
                m_row_msb = build_row(1);
                m_row_lsb = build_row(0);
                m_idx     = m_rows;
                m_valid   = 1;
              end else begin
                m_ovf = 1;
              end
              m_pix.delete();
              if (m_rows == ROWS - 1) begin
                m_rows = 0; m_state = M_DRAIN;
              end else begin
                m_rows++;
              end
            end
          end
          if (!done && xfer) m_valid = 0;
        end
      end
      default: begin
        if (iABORT) begin
          m_state = M_IDLE; model_clear_capture(); m_valid = 0;
        end else if (!m_valid || iROW_READY) begin
          m_valid = 0; m_state = M_IDLE; fin_n = 1;
        end
      end
    endcase
    m_fin = fin_n;
  endtask

  task automatic compare_model();
    bit busy = (m_state != M_IDLE);
    check("row_msb",  64'(row_m),   m_row_msb);
    check("row_lsb",  64'(row_l),   m_row_lsb);
    check("idx",      64'(idx_m),   64'(m_idx));
    check("idx_lsb",  64'(idx_l),   64'(m_idx));
    check("valid",    64'(valid_m), 64'(m_valid));
    check("valid_lsb",64'(valid_l), 64'(m_valid));
    check("busy",     64'(busy_m),  64'(busy));
    check("busy_lsb", 64'(busy_l),  64'(busy));
    check("finished", 64'(fin_m),   64'(m_fin));
    check("fin_lsb",  64'(fin_l),   64'(m_fin));
    check("overflow", 64'(ovf_m),   64'(m_ovf));
    check("ovf_lsb",  64'(ovf_l),   64'(m_ovf));
  endtask

  // One clock: inputs already driven, model advances on the edge, outputs
  // sampled 1 time unit later.
  task automatic step();
    @(posedge iCLK);
    model_step();
    #1;
    compare_model();
  endtask

  task automatic drive(input bit rst, input bit start, input bit abort,
                       input bit vld, input int pix, input bit rdy);
    iRST_n     = rst;
    iSTART     = start;
    iABORT     = abort;
    iVALID     = vld;
    iPIXEL     = PIX_W'(pix);
    iROW_READY = rdy;
  endtask

  task automatic idle_cycle(input bit rdy);
    drive(0, 0, 0, 0, 0, rdy);
    step();
  endtask

  // ---------------------------------------------------------------------------
  // Vector table for the basic frame (hand-derived expectations)
  // ---------------------------------------------------------------------------
  typedef struct {
    bit rst, start, abort, vld; int pix; bit rdy;
    logic [7:0] e_row, e_row_lsb; int e_idx;
    bit e_valid, e_busy, e_fin, e_ovf;
  } vec_t;

  vec_t tbl[12];
  int   frame_pix[8];

  initial begin
    frame_pix = '{3, 2, 1, 0, 1, 1, 2, 2};
    //          rst st ab vl px rd  row    lsb    idx v  b  f  o
    tbl[0]  = '{1, 0, 0, 0, 0, 1, 8'h00, 8'h00, 0, 0, 0, 0, 0};
    tbl[1]  = '{0, 1, 0, 0, 0, 1, 8'h00, 8'h00, 0, 0, 1, 0, 0};
    tbl[2]  = '{0, 0, 0, 1, 3, 1, 8'h00, 8'h00, 0, 0, 1, 0, 0};
    tbl[3]  = '{0, 0, 0, 1, 2, 1, 8'h00, 8'h00, 0, 0, 1, 0, 0};
    tbl[4]  = '{0, 0, 0, 1, 1, 1, 8'h00, 8'h00, 0, 0, 1, 0, 0};
    tbl[5]  = '{0, 0, 0, 1, 0, 1, 8'hE4, 8'h1B, 0, 1, 1, 0, 0};
    tbl[6]  = '{0, 0, 0, 1, 1, 1, 8'hE4, 8'h1B, 0, 0, 1, 0, 0};
    tbl[7]  = '{0, 0, 0, 1, 1, 1, 8'hE4, 8'h1B, 0, 0, 1, 0, 0};
    tbl[8]  = '{0, 0, 0, 1, 2, 1, 8'hE4, 8'h1B, 0, 0, 1, 0, 0};
    tbl[9]  = '{0, 0, 0, 1, 2, 1, 8'h5A, 8'hA5, 1, 1, 1, 0, 0};
    tbl[10] = '{0, 0, 0, 0, 0, 1, 8'h5A, 8'hA5, 1, 0, 0, 1, 0};
    tbl[11] = '{0, 0, 0, 0, 0, 1, 8'h5A, 8'hA5, 1, 0, 0, 0, 0};

    drive(1, 0, 0, 0, 0, 0);

    // Basic frame, both pixel orders.
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].rst, tbl[i].start, tbl[i].abort, tbl[i].vld, tbl[i].pix, tbl[i].rdy);
      step();
      check($sformatf("tbl%0d_row", i),      64'(row_m),   64'(tbl[i].e_row));
      check($sformatf("tbl%0d_row_lsb", i),  64'(row_l),   64'(tbl[i].e_row_lsb));
      check($sformatf("tbl%0d_idx", i),      64'(idx_m),   64'(tbl[i].e_idx));
      check($sformatf("tbl%0d_valid", i),    64'(valid_m), 64'(tbl[i].e_valid));
      check($sformatf("tbl%0d_busy", i),     64'(busy_m),  64'(tbl[i].e_busy));
      check($sformatf("tbl%0d_finished", i), 64'(fin_m),   64'(tbl[i].e_fin));
      check($sformatf("tbl%0d_overflow", i), 64'(ovf_m),   64'(tbl[i].e_ovf));
    end

    // Random iVALID gaps between pixels, consumer always ready.
    drive(0, 1, 0, 0, 0, 1); step();
    for (int i = 0; i < 8; i++) begin
      while ($urandom_range(2, 0) == 0) begin
        drive(0, 0, 0, 0, $urandom_range(3, 0), 1); step();
      end
      drive(0, 0, 0, 1, frame_pix[i], 1); step();
      if (i == 3) check("gap_row0", 64'(row_m), 64'h0E4);
    end
    check("gap_row1", 64'(row_m), 64'h05A);
    idle_cycle(1);
    check("gap_finished", 64'(fin_m), 64'd1);
    idle_cycle(1);

    // Consumer never ready: second row dropped, frame waits in DRAIN.
    drive(0, 1, 0, 0, 0, 0); step();
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 0, 1, frame_pix[i], 0); step();
    end
    check("stall_row_held", 64'(row_m), 64'h0E4);
    check("stall_idx_held", 64'(idx_m), 64'd0);
    check("stall_overflow", 64'(ovf_m), 64'd1);
    for (int i = 0; i < 5; i++) idle_cycle(0);
    check("stall_still_busy", 64'(busy_m), 64'd1);
    check("stall_no_finish",  64'(fin_m),  64'd0);
    idle_cycle(1);
    check("stall_finished", 64'(fin_m), 64'd1);
    check("stall_valid_low", 64'(valid_m), 64'd0);
    idle_cycle(1);
    check("overflow_sticky_idle", 64'(ovf_m), 64'd1);

    // Abort after two pixels of row 1, then a clean frame.
    drive(0, 1, 0, 0, 0, 1); step();
    check("restart_clears_ovf", 64'(ovf_m), 64'd0);
    for (int i = 0; i < 6; i++) begin
      drive(0, 0, 0, 1, frame_pix[i], 1); step();
    end
    drive(0, 0, 1, 1, 3, 1); step();
    check("abort_idle",  64'(busy_m),  64'd0);
    check("abort_valid", 64'(valid_m), 64'd0);
    check("abort_nofin", 64'(fin_m),   64'd0);
    idle_cycle(1);
    check("abort_nofin_later", 64'(fin_m), 64'd0);
    drive(0, 1, 0, 0, 0, 1); step();
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 0, 1, frame_pix[i], 1); step();
    end
    check("post_abort_row1", 64'(row_m), 64'h05A);
    check("post_abort_idx1", 64'(idx_m), 64'd1);
    idle_cycle(1);
    check("post_abort_fin", 64'(fin_m), 64'd1);

    // iSTART during RUN is ignored: counters keep going.
    drive(0, 1, 0, 0, 0, 0); step();
    for (int i = 0; i < 8; i++) begin
      drive(0, (i == 4 || i == 5), 0, 1, frame_pix[i], (i >= 6)); step();
    end
    check("start_ignored_row", 64'(row_m), 64'h05A);
    check("start_ignored_idx", 64'(idx_m), 64'd1);
    idle_cycle(1);

    // Reset mid-row while a row is held.
    drive(0, 1, 0, 0, 0, 0); step();
    for (int i = 0; i < 6; i++) begin
      drive(0, 0, 0, 1, frame_pix[i], 0); step();
    end
    check("pre_reset_valid", 64'(valid_m), 64'd1);
    drive(1, 1, 1, 1, 3, 1); step();
    check("reset_row",   64'(row_m),   64'd0);
    check("reset_idx",   64'(idx_m),   64'd0);
    check("reset_valid", 64'(valid_m), 64'd0);
    check("reset_busy",  64'(busy_m),  64'd0);
    check("reset_ovf",   64'(ovf_m),   64'd0);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      drive(($urandom_range(199, 0) == 0),
            ($urandom_range(7, 0) == 0),
            ($urandom_range(59, 0) == 0),
            ($urandom_range(9, 0) < 7),
            $urandom_range(3, 0),
            ($urandom_range(9, 0) < 6));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
